// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared state/phase types and sizing helper for the serial shift-out block
package shift_pkg;

  typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;
  typedef enum logic {SETUP, CLOCK} phase_t;

  localparam int MAX_WIDTH = 16;

  // Bit counter width for a given word width; one spare bit keeps the terminal count representable.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/shift_out_ctrl_phase_tick.sv
// rtl/shift_out_ctrl_phase_tick.sv - DIV-cycle phase prescaler, tick on the last cycle of each phase
module phase_tick #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  // Held at zero while disabled so every enable rising edge starts a full phase; DIV=1 leaves cnt at 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

  assign tick = enable && (cnt == LAST);

endmodule

// File: rtl/shift_out_ctrl.sv
// rtl/shift_out_ctrl.sv - 74HC595-style serial transmitter: shifts a word out on serdata/serclk, then pulses rclk
module shift_out_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int DIV       = 1,
  parameter int LSB_FIRST = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic             o_serdata,
  output logic             o_serclk,
  output logic             o_rclk,
  output logic             o_busy,
  output logic             o_done
);

  localparam int             CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_t           state, state_n;
  phase_t           phase, phase_n;
  logic [WIDTH-1:0] sreg, sreg_n, shifted;
  logic [CNT_W-1:0] bcnt, bcnt_n;
  logic             ready_n, serdata_n, serclk_n, rclk_n, busy_n, done_n;
  logic             tick;

  phase_tick #(.DIV(DIV)) u_phase_tick (
    .clk    (clk),
    .reset  (reset),
    .enable (state != IDLE),
    .tick   (tick)
  );

  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return (LSB_FIRST != 0) ? w[0] : w[WIDTH-1];
  endfunction

  assign shifted = (LSB_FIRST != 0) ? (sreg >> 1) : (sreg << 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= SETUP;
      sreg      <= '0;
      bcnt      <= '0;
      o_ready   <= 1'b0;
      o_serdata <= 1'b0;
      o_serclk  <= 1'b0;
      o_rclk    <= 1'b0;
      o_busy    <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      sreg      <= sreg_n;
      bcnt      <= bcnt_n;
      o_ready   <= ready_n;
      o_serdata <= serdata_n;
      o_serclk  <= serclk_n;
      o_rclk    <= rclk_n;
      o_busy    <= busy_n;
      o_done    <= done_n;
    end
  end

  // Next-state logic computes the registered value of every output, so no output has a combinational path.
  always_comb begin
    state_n   = state;
    phase_n   = phase;
    sreg_n    = sreg;
    bcnt_n    = bcnt;
    ready_n   = o_ready;
    serdata_n = o_serdata;
    serclk_n  = o_serclk;
    rclk_n    = o_rclk;
    busy_n    = o_busy;
    done_n    = 1'b0;
    case (state)
      IDLE: begin
        ready_n  = 1'b1;
        serclk_n = 1'b0;
        rclk_n   = 1'b0;
        busy_n   = 1'b0;
        if (i_valid && o_ready) begin
          state_n   = SHIFT;
          phase_n   = SETUP;
          sreg_n    = i_data;
          bcnt_n    = '0;
          serdata_n = first_bit(i_data);
          ready_n   = 1'b0;
          busy_n    = 1'b1;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (phase == SETUP) begin
            phase_n  = CLOCK;
            serclk_n = 1'b1;
          end else begin
            phase_n  = SETUP;
            serclk_n = 1'b0;
            sreg_n   = shifted;
            if (bcnt == LAST_BIT) begin
              state_n = LATCH;
              bcnt_n  = '0;
              rclk_n  = 1'b1;
            end else begin
              bcnt_n    = bcnt + CNT_W'(1);
              serdata_n = first_bit(shifted);
            end
          end
        end
      end
      LATCH: begin
        if (tick) begin
          state_n = IDLE;
          rclk_n  = 1'b0;
          busy_n  = 1'b0;
          ready_n = 1'b1;
          done_n  = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: doc/shift_out_ctrl.md
Name: shift_out_ctrl

Overview:
- Serial transmitter for a chain of serial-in/parallel-out shift registers (74HC595 style).
- Accepts a WIDTH-bit word over a valid/ready handshake and shifts it out on o_serdata/o_serclk.
- After the last bit, pulses the storage/latch clock o_rclk so the new word appears on the register outputs.
- Forms the output direction of our serial expander interface; pairs with the existing parallel-load input shifter.

Parameters:
- WIDTH, 8, bits per word, 2..16.
- DIV, 1, clk cycles per serial phase (serclk half-period), 1..255.
- LSB_FIRST, 0, 0 = MSB shifted first, 1 = LSB first.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- i_data  input  WIDTH  parallel word; sampled only on the handshake cycle.
- i_valid  input  1  word available.
- o_ready  output  1  block idle and can accept a word.
- o_serdata  output  1  serial data to the SER pin.
- o_serclk  output  1  shift clock to SRCLK; data is stable across its rising edge.
- o_rclk  output  1  latch clock to RCLK; one high phase per word.
- o_busy  output  1  transfer in progress (SHIFT or LATCH).
- o_done  output  1  one-cycle pulse when a word has been latched.

Behaviour:
- All outputs come directly from flops; there are no combinational output paths.
- Reset asserted, asynchronously: state=IDLE, shift reg=0, bit count=0, prescaler=0.
  - o_ready=0, o_serdata=0, o_serclk=0, o_rclk=0, o_busy=0, o_done=0.
  - o_ready rises on the first clk edge after reset deasserts.
- Reset mid-transfer aborts immediately. No rclk pulse is issued, and the partial word is discarded.
- Handshake: a transfer starts when i_valid && o_ready at a clk edge. i_data is captured at that edge.
  - o_ready drops the next cycle and stays low until the transfer completes.
  - i_valid while o_ready=0 is ignored.
- State machine: IDLE -> SHIFT -> LATCH -> IDLE.
  - IDLE: o_ready=1. o_serclk, o_rclk and o_busy are all 0.
  - SHIFT, per bit, two phases of DIV cycles each:
    - SETUP: o_serclk=0, o_serdata = current bit.
    - CLOCK: o_serclk=1, o_serdata held.
    - At the end of CLOCK: shift the register (left if MSB-first, right if LSB-first) and increment the bit count.
    - After bit WIDTH-1's CLOCK phase, go to LATCH.
  - LATCH, DIV cycles: o_serclk=0, o_rclk=1, o_serdata held at its last value.
  - Return to IDLE. In the first IDLE cycle o_done=1 for exactly one cycle and o_ready=1.
- o_serdata changes only at the start of a SETUP phase, never in the same cycle o_serclk rises.
- Timing, with the handshake edge as E0 and cycles numbered from 1:
  - Bit i: SETUP occupies cycles 2*i*DIV+1 .. (2i+1)*DIV; CLOCK occupies the next DIV cycles.
  - o_rclk is high for cycles 2*WIDTH*DIV+1 .. (2*WIDTH+1)*DIV.
  - o_done fires at cycle (2*WIDTH+1)*DIV+1.
- Back-to-back transfers: a handshake in the o_done cycle is legal.
  - The next SETUP begins the following cycle, so there is no dead cycle beyond IDLE.
- Widths:
  - Bit counter: $clog2(WIDTH)+1 bits. It wraps to 0 when entering LATCH.
  - Prescaler: 8 bits. It reloads at every phase boundary.
  - With DIV=1 the prescaler is bypassed and each phase is exactly 1 cycle.

Decomposition:
- Package shift_pkg holds:
  - state enum: IDLE, SHIFT, LATCH;
  - phase enum: SETUP, CLOCK;
  - localparam CNT_W = $clog2(WIDTH)+1.
- Sub-module phase_tick: DIV-cycle prescaler.
  - Inputs: clk, reset, enable.
  - Output: one-cycle tick at the end of each phase; it restarts on enable rising.
  - Instantiated once. The top level holds the FSM, the shift register and the output flops.

Test Plan:
- Reset with WIDTH=8, DIV=1 -> all outputs 0 during reset; o_ready=1 one clk after release.
- Send 0xA5 (MSB-first, WIDTH=8, DIV=1):
  - o_serdata sampled at the 8 o_serclk rising edges = 1,0,1,0,0,1,0,1;
  - serclk high in cycles 2,4,...,16;
  - o_rclk high in cycle 17 only;
  - o_done in cycle 18.
- LSB_FIRST=1, send 0x01 -> first sampled bit 1, remaining 7 bits 0. DIV=3 -> every phase lasts 3 cycles; o_done at cycle 52.
- Back-to-back: hold i_valid with 0xFF then 0x00 -> second handshake in the o_done cycle; no extra idle cycles; two o_rclk pulses 18 cycles apart.
- Busy hold-off: toggle i_valid and i_data during a transfer -> no effect on o_serdata; the captured word is unchanged.
- Assert reset during bit 4 -> outputs go to 0 immediately, no o_rclk or o_done pulse; a fresh word 0x3C after release shifts out correctly.
